// File: rtl/sad_search_sequencer_pkg.sv
// Shared types and constants for the SAD search sequencer and its best-SAD tracker.
package sad_search_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int SAD_W = 12;
    localparam logic [SAD_W-1:0] SAD_INIT = 12'hFFF;

    localparam int DEF_FRAME_W      = 64;
    localparam int DEF_FRAME_H      = 64;
    localparam int DEF_BLK          = 4;
    localparam int DEF_COORD_W      = 6;
    localparam int DEF_MAX_INFLIGHT = 7;

endpackage

// File: rtl/sad_search_sequencer_best_tracker.sv
// Running minimum of returned SAD values and the coordinates that produced it.
module sad_best_tracker
    import sad_search_sequencer_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               update,
    input  logic [SAD_W-1:0]   sad,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [SAD_W-1:0]   best_sad,
    output logic [COORD_W-1:0] best_x,
    output logic [COORD_W-1:0] best_y
);

    // Strict less-than keeps the earliest raster candidate on a tie.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            best_sad <= SAD_INIT;
            best_x   <= '0;
            best_y   <= '0;
        end else if (update && (sad < best_sad)) begin
            best_sad <= sad;
            best_x   <= x;
            best_y   <= y;
        end
    end

endmodule

// File: rtl/sad_search_sequencer.sv
// Raster-order candidate issue, in-flight tracking and minimum-SAD search control.
// Optional feature: define SAD_EARLY_EXIT_EN to stop issuing after an exact (zero) match.
module sad_search_sequencer
    import sad_search_sequencer_pkg::*;
#(
    parameter int FRAME_W      = DEF_FRAME_W,
    parameter int FRAME_H      = DEF_FRAME_H,
    parameter int BLK          = DEF_BLK,
    parameter int COORD_W      = DEF_COORD_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    output logic               CandValid,
    output logic [COORD_W-1:0] CandX,
    output logic [COORD_W-1:0] CandY,
    input  logic               SadValid,
    input  logic [SAD_W-1:0]   SadIn,
    input  logic [COORD_W-1:0] SadX,
    input  logic [COORD_W-1:0] SadY,
    output logic               Busy,
    output logic               Done,
    output logic [SAD_W-1:0]   BestSad,
    output logic [COORD_W-1:0] BestX,
    output logic [COORD_W-1:0] BestY,
    output logic               Err
);

    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [COORD_W-1:0] LAST_X  = COORD_W'(FRAME_W - BLK);
    localparam logic [COORD_W-1:0] LAST_Y  = COORD_W'(FRAME_H - BLK);
    localparam logic [INF_W-1:0]   INF_MAX = INF_W'(MAX_INFLIGHT);

    state_t             state, state_next;
    logic [COORD_W-1:0] pos_x, pos_y;
    logic [INF_W-1:0]   inflight;
    logic               quiet;
    logic               accept_start, in_search, sad_accept, sad_bad;
    logic               early_hit, issue, last_pos;

    // quiet is set by reset so results from an aborted search are dropped without flagging Err.
    always_comb begin
        accept_start = (state == S_IDLE) && Start;
        in_search    = (state == S_ISSUE) || (state == S_DRAIN);
        sad_accept   = SadValid && in_search && (inflight != '0);
        sad_bad      = SadValid && !sad_accept && !((state == S_IDLE) && quiet);
`ifdef SAD_EARLY_EXIT_EN
        early_hit    = sad_accept && (state == S_ISSUE) && (SadIn == '0);
`else
        early_hit    = 1'b0;
`endif
        issue        = (state == S_ISSUE) && !Stall && (inflight < INF_MAX) && !early_hit;
        last_pos     = (pos_x == LAST_X) && (pos_y == LAST_Y);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (Start) state_next = S_ISSUE;
            S_ISSUE: if ((issue && last_pos) || early_hit) state_next = S_DRAIN;
            S_DRAIN: if (inflight == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= S_IDLE;
            pos_x     <= '0;
            pos_y     <= '0;
            inflight  <= '0;
            quiet     <= 1'b1;
            CandValid <= 1'b0;
            CandX     <= '0;
            CandY     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_next;
            CandValid <= issue;
            Busy      <= (state_next == S_ISSUE) || (state_next == S_DRAIN);
            Done      <= (state_next == S_DONE);
            if (accept_start) begin
                pos_x <= '0;
                pos_y <= '0;
                quiet <= 1'b0;
                Err   <= 1'b0;
            end else begin
                if (sad_bad)
                    Err <= 1'b1;
                if (issue) begin
                    CandX <= pos_x;
                    CandY <= pos_y;
                    if (pos_x == LAST_X) begin
                        pos_x <= '0;
                        pos_y <= pos_y + COORD_W'(1);
                    end else begin
                        pos_x <= pos_x + COORD_W'(1);
                    end
                end
            end
            // An issue and a return in the same cycle cancel out.
            if (issue && !sad_accept)
                inflight <= inflight + INF_W'(1);
            else if (!issue && sad_accept)
                inflight <= inflight - INF_W'(1);
        end
    end

    sad_best_tracker #(
        .COORD_W (COORD_W)
    ) best_tracker (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (accept_start),
        .update   (sad_accept),
        .sad      (SadIn),
        .x        (SadX),
        .y        (SadY),
        .best_sad (BestSad),
        .best_x   (BestX),
        .best_y   (BestY)
    );

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Self-checking bench for sad_search_sequencer on an 8x8 window with a latency-modelled datapath.
// Exercises the SAD_EARLY_EXIT_EN scenario only when that macro is defined.
module tb_sad_search_sequencer;

    localparam int FW = 8, FH = 8, BK = 4, CW = 6, MI = 7;
    localparam int NX = FW - BK + 1;
    localparam int NY = FH - BK + 1;
    localparam int NCAND = NX * NY;
    localparam int KIND_REAL = 0, KIND_STALE = 1, KIND_BOGUS = 2;

    logic          Clk = 1'b0;
    logic          Reset, Start, Stall, SadValid;
    logic [11:0]   SadIn;
    logic [CW-1:0] SadX, SadY;
    logic          CandValid, Busy, Done, Err;
    logic [CW-1:0] CandX, CandY, BestX, BestY;
    logic [11:0]   BestSad;

    sad_search_sequencer #(
        .FRAME_W(FW), .FRAME_H(FH), .BLK(BK), .COORD_W(CW), .MAX_INFLIGHT(MI)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .CandValid(CandValid), .CandX(CandX), .CandY(CandY),
        .SadValid(SadValid), .SadIn(SadIn), .SadX(SadX), .SadY(SadY),
        .Busy(Busy), .Done(Done), .BestSad(BestSad), .BestX(BestX), .BestY(BestY),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Candidate SAD table in raster order and the in-order return pipeline
    int sad_tab[NCAND];
    int lat = 4;
    int cyc = 0;
    int ret_idx[$];
    int ret_time[$];
    bit ret_stale[$];

    logic stall_seen, start_seen, reset_seen;
    bit   live = 0, model_idle = 1, done_last = 0, exited = 0, model_err = 0;
    int   issued = 0, inflight = 0, done_cnt = 0, issued_at_zero = -1;
    int   m_best = 4095, m_bx = 0, m_by = 0;
    bit   pend_valid = 0;
    int   pend_idx = 0, pend_kind = KIND_REAL;
    bit   inject_bogus = 0, rand_stall = 0;
    int   bogus_val = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        applyStimulus(1);
        Start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            if (rand_stall) Stall = ($urandom_range(0, 3) == 0);
            applyStimulus(1);
        end
        Stall = 1'b0;
        applyStimulus(3);
        checkOutput("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    function automatic void scanBest(output int b, output int bx, output int by);
        b = 4095; bx = 0; by = 0;
        for (int i = 0; i < NCAND; i++)
            if (sad_tab[i] < b) begin
                b = sad_tab[i]; bx = i % NX; by = i / NX;
            end
    endfunction

    function automatic void fillRandom();
        for (int i = 0; i < NCAND; i++) sad_tab[i] = int'($urandom_range(1, 4095));
    endfunction

    // Input sampler: what the DUT saw at each rising edge
    initial forever begin
        @(posedge Clk);
        stall_seen = Stall;
        start_seen = Start;
        reset_seen = Reset;
    end

    // Behavioural model, datapath model and per-cycle compare
    initial begin
        bit live_b, drain_b, exp_issue, exp_done;
        int inf_b;
        SadValid = 1'b0; SadIn = '0; SadX = '0; SadY = '0;
        forever begin
            @(negedge Clk);
            cyc++;
            exp_issue = 0;
            exp_done  = 0;
            if (reset_seen !== 1'b1) begin
                live = 0; model_idle = 1; done_last = 0; exited = 0; model_err = 0;
                issued = 0; inflight = 0; m_best = 4095; m_bx = 0; m_by = 0;
                foreach (ret_stale[i]) ret_stale[i] = 1'b1;
            end else begin
                live_b  = live;
                inf_b   = inflight;
                drain_b = live && (issued >= NCAND || exited);
                if (start_seen === 1'b1 && model_idle) begin
                    live = 1; model_idle = 0; issued = 0; inflight = 0; exited = 0;
                    model_err = 0; m_best = 4095; m_bx = 0; m_by = 0;
                end
                if (pend_valid) begin
                    if (pend_kind == KIND_REAL) begin
                        inflight--;
                        if (sad_tab[pend_idx] < m_best) begin
                            m_best = sad_tab[pend_idx]; m_bx = pend_idx % NX; m_by = pend_idx / NX;
                        end
`ifdef SAD_EARLY_EXIT_EN
                        if (sad_tab[pend_idx] == 0 && live_b && !drain_b) begin
                            exited = 1; issued_at_zero = issued;
                        end
`endif
                    end else if (pend_kind == KIND_BOGUS) begin
                        model_err = 1;
                    end
                end
                exp_issue = live_b && !drain_b && !exited && (stall_seen === 1'b0) && inf_b < MI;
                exp_done  = drain_b && inf_b == 0;
            end
            pend_valid = 0;

            checkOutput("cand_valid", 32'(CandValid), 32'(exp_issue));
            if (CandValid === 1'b1) begin
                checkOutput("cand_x", 32'(CandX), 32'(issued % NX));
                checkOutput("cand_y", 32'(CandY), 32'(issued / NX));
                if (issued < NCAND) begin
                    ret_idx.push_back(issued);
                    ret_time.push_back(cyc + lat);
                    ret_stale.push_back(1'b0);
                end
                issued++;
                inflight++;
            end
            checkOutput("done", 32'(Done), 32'(exp_done));
            if (Done === 1'b1) done_cnt++;
            if (exp_done) live = 0;
            checkOutput("busy", 32'(Busy), 32'(live));
            checkOutput("best_sad", 32'(BestSad), m_best);
            checkOutput("best_x", 32'(BestX), m_bx);
            checkOutput("best_y", 32'(BestY), m_by);
            checkOutput("err", 32'(Err), 32'(model_err));
            if (done_last) model_idle = 1;
            done_last = exp_done;

            SadValid = 1'b0;
            if (ret_time.size() > 0 && ret_time[0] <= cyc) begin
                pend_idx  = ret_idx.pop_front();
                void'(ret_time.pop_front());
                pend_kind = ret_stale.pop_front() ? KIND_STALE : KIND_REAL;
                pend_valid = 1;
                SadValid = 1'b1;
                SadIn = 12'(sad_tab[pend_idx]);
                SadX  = CW'(pend_idx % NX);
                SadY  = CW'(pend_idx / NX);
            end else if (inject_bogus) begin
                inject_bogus = 0;
                pend_kind  = KIND_BOGUS;
                pend_valid = 1;
                SadValid = 1'b1;
                SadIn = 12'(bogus_val);
                SadX  = CW'(3);
                SadY  = CW'(3);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, s0, b, bx, by;
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0;
        applyStimulus(2);
        checkOutput("rst_cand_valid", 32'(CandValid), 32'd0);
        checkOutput("rst_cand_x", 32'(CandX), 32'd0);
        checkOutput("rst_cand_y", 32'(CandY), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_best_sad", 32'(BestSad), 32'hFFF);
        checkOutput("rst_best_x", 32'(BestX), 32'd0);
        checkOutput("rst_best_y", 32'(BestY), 32'd0);
        checkOutput("rst_err", 32'(Err), 32'd0);
        Reset = 1'b1;
        applyStimulus(1);

        // Plain scan: single minimum of 40 at (2,1)
        for (int i = 0; i < NCAND; i++) sad_tab[i] = 100;
        sad_tab[1 * NX + 2] = 40;
        lat = 4;
        d0 = done_cnt;
        pulseStart();
        waitDone(d0, 400);
        checkOutput("t1_issued", issued, 25);
        checkOutput("t1_best_sad", 32'(BestSad), 32'd40);
        checkOutput("t1_best_x", 32'(BestX), 32'd2);
        checkOutput("t1_best_y", 32'(BestY), 32'd1);

        // Stall at (3,0), tie of 7 at (1,0) and (3,2), long latency, ignored Start
        for (int i = 0; i < NCAND; i++) sad_tab[i] = 50;
        sad_tab[0 * NX + 1] = 7;
        sad_tab[2 * NX + 3] = 7;
        lat = 10;
        d0 = done_cnt;
        pulseStart();
        for (int i = 0; i < 50 && issued < 3; i++) applyStimulus(1);
        Stall = 1'b1;
        s0 = issued;
        applyStimulus(5);
        Stall = 1'b0;
        checkOutput("t2_stall_hold", issued, s0);
        pulseStart();
        waitDone(d0, 600);
        checkOutput("t2_issued", issued, 25);
        checkOutput("t2_best_sad", 32'(BestSad), 32'd7);
        checkOutput("t2_best_x", 32'(BestX), 32'd1);
        checkOutput("t2_best_y", 32'(BestY), 32'd0);

        // Reset mid-search, stale returns, then a clean rerun
        fillRandom();
        lat = 6;
        pulseStart();
        for (int i = 0; i < 100 && issued < 10; i++) applyStimulus(1);
        Reset = 1'b0;
        applyStimulus(1);
        Reset = 1'b1;
        checkOutput("t3_cand_valid", 32'(CandValid), 32'd0);
        checkOutput("t3_busy", 32'(Busy), 32'd0);
        checkOutput("t3_best_sad", 32'(BestSad), 32'hFFF);
        applyStimulus(15);
        checkOutput("t3_stale_err", 32'(Err), 32'd0);
        fillRandom();
        d0 = done_cnt;
        pulseStart();
        waitDone(d0, 600);
        scanBest(b, bx, by);
        checkOutput("t3_best_sad", 32'(BestSad), b);
        checkOutput("t3_best_x", 32'(BestX), bx);
        checkOutput("t3_best_y", 32'(BestY), by);

        // Result while idle sets Err; best holds; next Start clears Err
        bogus_val = 0;
        inject_bogus = 1;
        applyStimulus(3);
        checkOutput("t4_err_set", 32'(Err), 32'd1);
        checkOutput("t4_best_hold", 32'(BestSad), b);
        for (int run = 0; run < 4; run++) begin
            fillRandom();
            lat = int'($urandom_range(1, 12));
            rand_stall = 1;
            d0 = done_cnt;
            pulseStart();
            if (run == 0) checkOutput("t4_err_clear", 32'(Err), 32'd0);
            waitDone(d0, 1000);
            rand_stall = 0;
            scanBest(b, bx, by);
            checkOutput("rand_issued", issued, NCAND);
            checkOutput("rand_best_sad", 32'(BestSad), b);
        end

`ifdef SAD_EARLY_EXIT_EN
        // Exact match at (1,0) stops issue early
        for (int i = 0; i < NCAND; i++) sad_tab[i] = 100;
        sad_tab[1] = 0;
        lat = 3;
        d0 = done_cnt;
        pulseStart();
        waitDone(d0, 400);
        checkOutput("ee_issue_stop", issued, issued_at_zero);
        checkOutput("ee_best_sad", 32'(BestSad), 32'd0);
        checkOutput("ee_best_x", 32'(BestX), 32'd1);
        checkOutput("ee_best_y", 32'(BestY), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
